// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array and its feeder.
// Lane m of any packed lane bus starts at bit m*width.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } feed_state_e;

  function automatic int lane_lo(
    input int m,
    input int w
  );
    return m * w;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Zero-reset shift chain of DEPTH registers; shifts every clock.
// Used to delay one operand lane by its diagonal position.
module skew_line #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] sr;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= '0;
      else     sr <= d;
    end
  end else begin : g_many
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= '0;
      else     sr <= {sr[DEPTH-2:0], d};
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Transmit side of the skewed-wavefront array interface: accepts
// unskewed A-column/B-row beats, skews lane m by m cycles, flushes.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIM        = 3,
  parameter int K_MAX      = 64,
  parameter int KW         = $clog2(K_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH*DIM-1:0] in_a,
  input  logic [DATA_WIDTH*DIM-1:0] in_b,
  output logic [DATA_WIDTH*DIM-1:0] feed_1,
  output logic [DATA_WIDTH*DIM-1:0] feed_2,
  output logic                      acc_clr,
  output logic                      busy,
  output logic                      done
);

  localparam int FLUSH_LEN = 2 * DIM - 1;
  localparam int FW = $clog2(FLUSH_LEN + 1);

  feed_state_e   state;
  logic [KW-1:0] k_lat;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] fl_cnt;
  logic [KW-1:0] k_clip;
  logic          accept;
  logic          last_beat;

  // in_ready is only ever high in STREAM
  assign accept    = in_valid && in_ready;
  assign last_beat = KW'(beat_cnt + 1'b1) == k_lat;
  assign k_clip    = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k_lat    <= '0;
      beat_cnt <= '0;
      fl_cnt   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_clr  <= 1'b0;
    end else begin
      acc_clr <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc_clr <= 1'b1;
            if (k_len == '0) begin
              done <= 1'b1;
            end else begin
              k_lat    <= k_clip;
              beat_cnt <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              in_ready <= 1'b0;
              fl_cnt   <= '0;
              state    <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (fl_cnt == FW'(FLUSH_LEN - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            fl_cnt <= fl_cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Non-accept cycles inject zeros so the wavefront stays aligned
  for (genvar m = 0; m < DIM; m++) begin : g_lane
    localparam int LO = lane_lo(m, DATA_WIDTH);

    skew_line #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (m + 1)
    ) u_b (
      .clk(clk),
      .rst(rst),
      .d  (accept ? in_b[LO +: DATA_WIDTH] : '0),
      .q  (feed_1[LO +: DATA_WIDTH])
    );

    skew_line #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (m + 1)
    ) u_a (
      .clk(clk),
      .rst(rst),
      .d  (accept ? in_a[LO +: DATA_WIDTH] : '0),
      .q  (feed_2[LO +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a small 3x3
// output-stationary array model on its feeds.
module tb_systolic_feeder;

  localparam int DW  = 16;
  localparam int DIM = 3;
  localparam int KW  = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW*DIM-1:0] in_a = '0;
  logic [DW*DIM-1:0] in_b = '0;
  logic [DW*DIM-1:0] feed_1;
  logic [DW*DIM-1:0] feed_2;
  logic            acc_clr;
  logic            busy;
  logic            done;

  int tests_run = 0;
  int tests_failed = 0;

  int A [3][3];
  int B [3][3];

  systolic_feeder #(
    .DATA_WIDTH(DW),
    .DIM       (DIM),
    .K_MAX     (64),
    .KW        (KW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .k_len   (k_len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a    (in_a),
    .in_b    (in_b),
    .feed_1  (feed_1),
    .feed_2  (feed_2),
    .acc_clr (acc_clr),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // array model: A flows right along rows, B flows down columns
  logic [DW-1:0] ar [3][3];
  logic [DW-1:0] br [3][3];
  int acc [3][3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          ar[i][j] <= '0;
          br[i][j] <= '0;
          acc[i][j] <= 0;
        end
    end else begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          logic [DW-1:0] ai;
          logic [DW-1:0] bi;
          ai = (j == 0) ? feed_2[i*DW +: DW] : ar[i][j-1];
          bi = (i == 0) ? feed_1[j*DW +: DW] : br[i-1][j];
          ar[i][j] <= ai;
          br[i][j] <= bi;
          if (acc_clr) acc[i][j] <= 0;
          else acc[i][j] <= acc[i][j] + int'(ai) * int'(bi);
        end
    end
  end

  function automatic logic [47:0] pack3(
    input int l2, input int l1, input int l0
  );
    return {16'(l2), 16'(l1), 16'(l0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({feed_1, feed_2} !== '0) begin
      tests_failed++;
      $display("FAIL reset_feeds got=%h/%h exp=0", feed_1, feed_2);
    end
    tests_run++;
    if ({in_ready, busy, done, acc_clr} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl got=%b exp=0000",
               {in_ready, busy, done, acc_clr});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [47:0] e1 [7];
    logic [47:0] e2 [7];
    start = 1'b1;
    k_len = 7'd1;
    tick();
    start = 1'b0;
    tests_run++;
    if ({acc_clr, busy, in_ready} !== 3'b111) begin
      tests_failed++;
      $display("FAIL single_start got=%b exp=111",
               {acc_clr, busy, in_ready});
    end
    in_valid = 1'b1;
    in_a = pack3(3, 2, 1);
    in_b = pack3(6, 5, 4);
    e2 = '{48'h0, pack3(0, 0, 1), pack3(0, 2, 0),
           pack3(3, 0, 0), 48'h0, 48'h0, 48'h0};
    e1 = '{48'h0, pack3(0, 0, 4), pack3(0, 5, 0),
           pack3(6, 0, 0), 48'h0, 48'h0, 48'h0};
    for (int n = 0; n < 7; n++) begin
      tests_run++;
      if (feed_1 !== e1[n] || feed_2 !== e2[n]) begin
        tests_failed++;
        $display("FAIL single_feed c+%0d got=%h/%h exp=%h/%h",
                 n, feed_1, feed_2, e1[n], e2[n]);
      end
      tests_run++;
      if (done !== (n == 6)) begin
        tests_failed++;
        $display("FAIL single_done c+%0d got=%b exp=%b",
                 n, done, n == 6);
      end
      if (n == 1) begin
        tests_run++;
        if (in_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL single_ready_drop got=%b exp=0", in_ready);
        end
      end
      tick();
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
    end
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_idle got=%b exp=00", {busy, done});
    end
  endtask

  task automatic run_job(
    input  int    k,
    input  int    gap,
    input  string nm,
    output int    tot
  );
    int t;
    int n;
    int ev;
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
    t = 1;
    tests_run++;
    if (acc_clr !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_acc_clr got=%b exp=1", nm, acc_clr);
    end
    for (int b = 0; b < k; b++) begin
      if (b == 1)
        repeat (gap) begin
          tick();
          t++;
        end
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s_ready beat%0d got=%b exp=1",
                 nm, b, in_ready);
      end
      in_valid = 1'b1;
      in_a = pack3(A[2][b], A[1][b], A[0][b]);
      in_b = pack3(B[b][2], B[b][1], B[b][0]);
      tick();
      t++;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
    end
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
      t++;
    end
    tests_run++;
    if (n != 6) begin
      tests_failed++;
      $display("FAIL %s_done_lat got=%0d exp=6", nm, n);
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ev = 0;
        for (int b = 0; b < k; b++) ev += A[i][b] * B[b][j];
        tests_run++;
        if (acc[i][j] !== ev) begin
          tests_failed++;
          $display("FAIL %s_c[%0d][%0d] got=%0d exp=%0d",
                   nm, i, j, acc[i][j], ev);
        end
      end
    tick();
    tests_run++;
    if ({busy, done, feed_1, feed_2} !== '0) begin
      tests_failed++;
      $display("FAIL %s_idle got busy=%b done=%b", nm, busy, done);
    end
    tot = t;
  endtask

  task automatic test_back_to_back();
    int tot;
    run_job(3, 0, "full", tot);
    tests_run++;
    if (tot != 9) begin
      tests_failed++;
      $display("FAIL full_total got=%0d exp=9", tot);
    end
  endtask

  task automatic test_bubbles();
    int tot;
    run_job(3, 2, "bubble", tot);
    tests_run++;
    if (tot != 11) begin
      tests_failed++;
      $display("FAIL bubble_total got=%0d exp=11", tot);
    end
  endtask

  task automatic test_kzero();
    start = 1'b1;
    k_len = '0;
    tick();
    start = 1'b0;
    tests_run++;
    if ({acc_clr, done, busy, in_ready} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL kzero_pulse got=%b exp=1100",
               {acc_clr, done, busy, in_ready});
    end
    tick();
    tests_run++;
    if ({acc_clr, done, busy, feed_1, feed_2} !== '0) begin
      tests_failed++;
      $display("FAIL kzero_after got=%b exp=000",
               {acc_clr, done, busy});
    end
  endtask

  task automatic test_start_busy();
    int n;
    start = 1'b1;
    k_len = 7'd2;
    tick();
    k_len = 7'd5;
    in_valid = 1'b1;
    in_a = pack3(1, 1, 1);
    in_b = pack3(1, 1, 1);
    tick();
    tick();
    in_valid = 1'b0;
    start = 1'b0;
    in_a = '0;
    in_b = '0;
    tests_run++;
    if ({in_ready, busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL busy_len got=%b exp=01", {in_ready, busy});
    end
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (n != 6) begin
      tests_failed++;
      $display("FAIL busy_done_lat got=%0d exp=6", n);
    end
    tick();
  endtask

  task automatic test_reset_mid_job();
    int tot;
    start = 1'b1;
    k_len = 7'd3;
    tick();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_a = pack3(9, 8, 7);
      in_b = pack3(6, 5, 4);
      tick();
    end
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({feed_1, feed_2, in_ready, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_out got=%h/%h rdy=%b busy=%b",
               feed_1, feed_2, in_ready, busy);
    end
    tick();
    rst = 1'b0;
    tick();
    run_job(1, 0, "after_rst", tot);
  endtask

  initial begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        A[i][j] = (i == j) ? 1 : 0;
        B[i][j] = 3 * i + j + 1;
      end
    test_reset();
    test_single();
    test_back_to_back();
    test_bubbles();
    test_kzero();
    test_start_busy();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
